// File: rtl/seq_pattern_tx_if.sv
// Load/control handshake and serial output bundle for seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, pattern, len, reps, gap, abort,
    input  load_ready, x, x_valid, busy, done
  );

  modport slave (
    input  load_valid, pattern, len, reps, gap, abort,
    output load_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pattern[len:0] MSB-first, repeated reps+1
// times with gap idle cycles between frames; all outputs registered.
module seq_pattern_tx #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.abort && bus.load_valid) begin
          pat_d   = bus.pattern;
          len_d   = bus.len;
          reps_d  = bus.reps;
          gap_d   = bus.gap;
          idx_d   = bus.len;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          if (reps_q == '0) begin
            state_d = DONE;
          end else begin
            reps_d = reps_q - 1'b1;
            if (gap_q == '0) begin
              idx_d = len_q;
            end else begin
              // gcnt counts the remaining idle cycles after the current one
              gcnt_d  = gap_q - 1'b1;
              state_d = GAP;
            end
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gcnt_q == '0) begin
          idx_d   = len_q;
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    xv_d    = (state_d == SEND);
    x_d     = xv_d & pat_d[idx_d];
    busy_d  = (state_d == SEND) || (state_d == GAP);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      gcnt_q  <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.x_valid    = xv_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: per-cycle expected output records are
// queued at acceptance and compared on each falling edge.
module tb_seq_pattern_tx;
  localparam int PAT_W = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int xv_cnt   = 0;
  int y_cnt    = 0;
  int rec_no   = 0;
  logic [2:0] hist = '0;
  logic [4:0] exp_q[$];

  // record layout: {load_ready, busy, done, x_valid, x}
  function automatic logic [4:0] rec(input bit rdy, input bit bsy, input bit dn,
                                     input bit xv, input bit xb);
    return {rdy, bsy, dn, xv, xb};
  endfunction

  function automatic logic [4:0] obs();
    return {bus.load_ready, bus.busy, bus.done, bus.x_valid, bus.x};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // 101 detector model (overlapping) plus scoreboard pop
  always @(negedge clk) begin
    logic [4:0] e;
    hist = {hist[1:0], bus.x};
    if (hist == 3'b101) y_cnt++;
    if (bus.x_valid === 1'b1) xv_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("stream#%0d", rec_no), 32'(obs()), 32'(e));
      rec_no++;
    end
  end

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) @(posedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic send(input logic [PAT_W-1:0] pat, input int len, input int reps,
                      input int gap, input bit poke_busy);
    @(posedge clk); #1;
    bus.pattern    = pat;
    bus.len        = CNT_W'(len);
    bus.reps       = CNT_W'(reps);
    bus.gap        = CNT_W'(gap);
    bus.load_valid = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    y_cnt  = 0;
    xv_cnt = 0;
    for (int f = 0; f <= reps; f++) begin
      for (int i = len; i >= 0; i--) exp_q.push_back(rec(0, 1, 0, 1, pat[i]));
      if (f < reps)
        for (int g = 0; g < gap; g++) exp_q.push_back(rec(0, 1, 0, 0, 0));
    end
    exp_q.push_back(rec(0, 0, 1, 0, 0));
    exp_q.push_back(rec(1, 0, 0, 0, 0));
    if (poke_busy) begin
      bus.load_valid = 1'b1;
      bus.pattern    = ~pat;
      bus.len        = '0;
      bus.reps       = '0;
      bus.gap        = '0;
      repeat (3) @(posedge clk);
      #1 bus.load_valid = 1'b0;
    end
    drain("drain");
    check("xv_total", 32'(xv_cnt), 32'((len + 1) * (reps + 1)));
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.pattern    = '0;
    bus.len        = '0;
    bus.reps       = '0;
    bus.gap        = '0;
    bus.abort      = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_state", 32'(obs()), 32'(rec(1, 0, 0, 0, 0)));
    @(posedge clk); #1 rst = 1'b1;

    send(16'h0005, 2, 0, 0, 1'b0);
    check("y_single", 32'(y_cnt), 32'd1);
    send(16'hA5C3, 15, 0, 0, 1'b1);
    send(16'h0005, 2, 2, 3, 1'b0);
    send(16'h0005, 2, 1, 0, 1'b0);
    check("y_b2b", 32'(y_cnt), 32'd2);
    send(16'h8001, 15, 1, 1, 1'b0);

    // abort during second bit, with load_valid held while busy
    @(posedge clk); #1;
    bus.pattern = 16'h0005; bus.len = 4'd2; bus.reps = '0; bus.gap = '0;
    bus.load_valid = 1'b1;
    @(posedge clk); #1 bus.load_valid = 1'b0;
    @(negedge clk) check("abort_bit0", 32'(obs()), 32'(rec(0, 1, 0, 1, 1)));
    @(posedge clk); #1;
    bus.abort = 1'b1; bus.load_valid = 1'b1; bus.pattern = 16'hFFFF;
    @(negedge clk) check("abort_bit1", 32'(obs()), 32'(rec(0, 1, 0, 1, 0)));
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.load_valid = 1'b0;
    @(negedge clk) check("abort_idle", 32'(obs()), 32'(rec(1, 0, 0, 0, 0)));
    @(negedge clk) check("abort_nodone", 32'(obs()), 32'(rec(1, 0, 0, 0, 0)));

    // abort beats a simultaneous load in IDLE
    @(posedge clk); #1;
    bus.abort = 1'b1; bus.load_valid = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.load_valid = 1'b0;
    @(negedge clk) check("abort_prio", 32'(obs()), 32'(rec(1, 0, 0, 0, 0)));

    // abort while in DONE leaves the done pulse intact
    @(posedge clk); #1;
    bus.pattern = 16'h0001; bus.len = '0; bus.reps = '0; bus.gap = '0;
    bus.load_valid = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    exp_q.push_back(rec(0, 1, 0, 1, 1));
    exp_q.push_back(rec(0, 0, 1, 0, 0));
    exp_q.push_back(rec(1, 0, 0, 0, 0));
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    drain("drain_done_abort");

    // asynchronous reset mid-frame, then a fresh load
    @(posedge clk); #1;
    bus.pattern = 16'hA5C3; bus.len = 4'd15; bus.reps = 4'd1; bus.gap = 4'd2;
    bus.load_valid = 1'b1;
    @(posedge clk); #1 bus.load_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1 check("rst_async", 32'(obs()), 32'(rec(1, 0, 0, 0, 0)));
    @(posedge clk); #1 rst = 1'b1;
    send(16'h0005, 2, 0, 0, 1'b0);
    check("y_after_rst", 32'(y_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 16, sets the pattern register width in bits.
REQ-002 Parameter CNT_W, default 4, sets the width of the len, reps and gap fields; len SHALL be able to index every pattern bit (2^CNT_W >= PAT_W).
REQ-003 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 load_valid  input  1  request to start a transmission with the fields below.
REQ-006 load_ready  output  1  high when a request can be accepted.
REQ-007 pattern  input  PAT_W  bits to send, MSB-first starting at index len.
REQ-008 len  input  CNT_W  number of bits per frame minus 1 (0 = 1 bit, 15 = 16 bits).
REQ-009 reps  input  CNT_W  number of extra frame repetitions (total frames = reps+1).
REQ-010 gap  input  CNT_W  number of idle cycles inserted between frames.
REQ-011 abort  input  1  synchronous cancel of the current transmission.
REQ-012 x  output  1  serial data bit; intended to drive the x input of the 101 sequence detector.
REQ-013 x_valid  output  1  high while x carries a pattern bit.
REQ-014 busy  output  1  high in the SEND and GAP states.
REQ-015 done  output  1  one-cycle pulse when all frames have completed.

Function
REQ-016 States: IDLE, SEND, GAP, DONE; all outputs SHALL be registered.
REQ-017 Acceptance: load_valid=1 and load_ready=1 at a clock edge captures pattern/len/reps/gap and moves the FSM to SEND.
REQ-018 load_ready=1 only in IDLE; load_valid is ignored in every other state and the captured fields are unchanged.
REQ-019 Latency: the first bit, pattern[len], appears on x with x_valid=1 in the cycle immediately after the accepting edge.
REQ-020 SEND emits one bit per cycle in index order len, len-1, ..., 0.
REQ-021 After bit 0 with repetitions remaining and gap>0: GAP for exactly gap cycles with x=0 and x_valid=0, then SEND restarts at index len.
REQ-022 After bit 0 with repetitions remaining and gap=0: bit len of the next frame follows bit 0 back-to-back, with no idle cycle.
REQ-023 After bit 0 of the last frame: DONE for one cycle with done=1, x_valid=0, x=0, load_ready=0; IDLE follows.
REQ-024 The repetition counter decrements once per completed frame; it never wraps, and reps=0 yields exactly one frame.
REQ-025 Outside SEND: x=0 and x_valid=0.
REQ-026 abort=1 in SEND or GAP: next state IDLE, x_valid=0, busy=0, no done pulse.
REQ-027 abort=1 in IDLE: abort takes priority, so a simultaneous load_valid is not accepted; abort in DONE does not suppress the done pulse already in progress.
REQ-028 Total x_valid cycles per transaction SHALL equal (len+1)*(reps+1).

Reset
REQ-029 rst=0 forces, immediately and asynchronously: state IDLE, x=0, x_valid=0, busy=0, done=0, load_ready=1, all counters 0.
REQ-030 Reset asserted mid-transmission abandons the transfer; after release the block accepts a new load on the first edge with load_valid=1.

Verification
REQ-031 pattern=16'h0005, len=2, reps=0, gap=0 -> x=1,0,1 with x_valid over 3 cycles, done in the 4th cycle; a 101 detector driven by x asserts y=1 once.
REQ-032 pattern=16'hA5C3, len=15 -> 16 bits 1010_0101_1100_0011 MSB-first; done the cycle after the last bit; busy high for 16 cycles.
REQ-033 pattern=16'h0005, len=2, reps=2, gap=3 -> 101, 3 idle cycles, 101, 3 idle cycles, 101, done; 9 x_valid cycles in total.
REQ-034 pattern=16'h0005, len=2, reps=1, gap=0 -> contiguous 101101, 6 x_valid cycles; an overlapping detector fires twice.
REQ-035 abort asserted during the 2nd bit of a 3-bit frame -> x_valid=0 and load_ready=1 on the next cycle, no done pulse; load_valid asserted while busy is not accepted.
REQ-036 rst driven to 0 mid-frame between clock edges -> all outputs at their reset values before the next edge; a new load after release transmits correctly.
